id_ex_hazard_ctrl: RTL and testbench
====================================

# id_ex_hazard_ctrl

Pipeline hazard controller that sequences the PC, IF/ID and ID/EX pipeline registers of the 5-stage core. It detects load-use hazards, squashes wrong-path instructions on taken branches, and freezes the whole pipeline while the data memory is not ready, with a timeout watchdog. It sits beside the ID stage. Its outputs drive PC write-enable, IF/ID write and flush, the ID/EX control-bubble mux and the downstream stage holds.

## Interface
- TIMEOUT, 255: wait cycles in MEM_WAIT before mem_timeout sets; legal range 1..2^CNT_W-1.
- CNT_W, 8: width of the memory-wait counter.
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset; 0 = reset asserted.
- id_rs  input  5  rs field of the instruction in ID.
- id_rt  input  5  rt field of the instruction in ID.
- id_uses_rt  input  1  ID instruction reads rt.
- ex_mem_read  input  1  EX-stage instruction is a load (ID/EX M memread bit).
- ex_rt  input  5  destination rt of the EX-stage instruction.
- branch_taken  input  1  branch resolved taken in EX this cycle.
- dmem_req  input  1  MEM stage has an access pending.
- dmem_ready  input  1  data memory completes the access this cycle.
- pc_write  output  1  PC update enable.
- if_id_write  output  1  IF/ID load enable.
- if_id_flush  output  1  IF/ID loads a NOP.
- id_ex_bubble  output  1  ID/EX loads zero WB/M/EX control.
- pipe_hold  output  1  freezes ID/EX, EX/MEM and MEM/WB.
- mem_timeout  output  1  sticky watchdog flag.
- load_stall_cnt, flush_cnt, mem_wait_cnt  output  32 each  event counters (STALL_CNT_EN only).

## Operation
- States: RUN, MEM_WAIT. Reset state is RUN.
- memwait = dmem_req & ~dmem_ready.
- branch = branch_taken.
- loaduse = ex_mem_read & (ex_rt != 0) & ((ex_rt == id_rs) | (id_uses_rt & ex_rt == id_rt)).
- Priority: memwait > branch > loaduse > normal.
- memwait (either state):
  - Outputs: pipe_hold=1, pc_write=0, if_id_write=0, id_ex_bubble=0, if_id_flush=0.
  - Next state: MEM_WAIT.
- branch, no memwait:
  - Outputs: pc_write=1, if_id_write=1, if_id_flush=1, id_ex_bubble=1, pipe_hold=0.
  - Effect: the two wrong-path instructions are squashed.
  - A concurrent loaduse is ignored.
- loaduse, no memwait, no branch:
  - Outputs: pc_write=0, if_id_write=0, id_ex_bubble=1, others 0.
  - Exactly one bubble is inserted: the next cycle the load is in MEM and the condition clears.
- Normal:
  - Outputs: pc_write=1, if_id_write=1, others 0.
- MEM_WAIT:
  - wait_cnt increments each cycle while memwait holds.
  - When wait_cnt == TIMEOUT, mem_timeout sets and stays set until reset.
  - wait_cnt saturates at TIMEOUT.
  - dmem_ready=1 releases the pipeline: outputs follow priority in that same cycle, state returns to RUN and wait_cnt clears.
  - dmem_req dropping also exits to RUN.
- A branch_taken held during MEM_WAIT is acted on in the first unfrozen cycle. The pipeline registers are frozen, so branch_taken stays asserted.

## Timing
- Outputs are combinational from state and inputs; zero-cycle latency from hazard to control.
- state, wait_cnt, mem_timeout and the counters update on the rising edge of clk.
- While reset=0, regardless of clk:
  - pc_write=0, if_id_write=0, if_id_flush=1, id_ex_bubble=1, pipe_hold=0.
  - mem_timeout=0, state=RUN, wait_cnt=0, all counters 0.
- Reset asserted mid-MEM_WAIT aborts the wait immediately. After release the block starts in RUN.
- Single-cycle dmem_ready latency: if dmem_ready=1 in the request cycle, there is no hold and no MEM_WAIT entry.
- ex_rt=0 never stalls; register $zero carries no hazard.

## Configuration
- STALL_CNT_EN defined:
  - load_stall_cnt, flush_cnt and mem_wait_cnt each count cycles where loaduse, branch or memwait (respectively) wins priority.
  - 32-bit, saturating at 0xFFFFFFFF.
- STALL_CNT_EN undefined:
  - The counters are not built.
  - The three ports are tied to 0.
  - All other behaviour is identical.

## Test plan
- Reset=0 with dmem_req=1, branch_taken=1 -> if_id_flush=1, id_ex_bubble=1, pc_write=0, pipe_hold=0; after release, state RUN, mem_timeout=0.
- ex_mem_read=1, ex_rt=5, id_rs=5 for one cycle -> pc_write=0, if_id_write=0, id_ex_bubble=1 that cycle; next cycle (ex_mem_read=0) normal outputs; load_stall_cnt=1.
  - Repeat with ex_rt=0 -> no stall.
  - Repeat with id_rt=5, id_uses_rt=0 -> no stall.
- branch_taken=1 together with a loaduse match -> pc_write=1, if_id_flush=1, id_ex_bubble=1; flush_cnt=1; load_stall_cnt unchanged.
- dmem_req=1, dmem_ready=0 for 3 cycles, then ready=1 -> pipe_hold=1 for 3 cycles, 0 in the ready cycle; mem_wait_cnt=3; state RUN afterwards.
- TIMEOUT=4, dmem_ready held 0 -> mem_timeout rises at the 4th MEM_WAIT edge.
  - Stays 1 after dmem_ready=1.
  - Clears only on reset.
- branch_taken=1 during a 2-cycle memwait -> no flush while held; flush asserted in the first cycle after dmem_ready=1.

Source files
------------

// File: rtl/id_ex_hazard_ctrl_if.sv
// id_ex_hazard_ctrl_if
//
// Signal bundle between the ID-stage hazard controller and the pipeline.
//
// Handshake: there is no valid/ready flow control on this bundle. All
// hazard inputs are level signals sampled combinationally every cycle. All
// control outputs are combinational and take effect in the same cycle.
// dmem_req/dmem_ready form a level request/complete pair: an access
// completes in the cycle where both are high.
//
// Modports:
//   master - pipeline side: drives hazard inputs, receives control.
//   slave  - hazard controller: receives hazard inputs, drives control,
//            event counters and the debug view (state, wait_cnt).
interface id_ex_hazard_ctrl_if #(
    parameter int CNT_W = 8
);
    logic [4:0]       id_rs;
    logic [4:0]       id_rt;
    logic             id_uses_rt;
    logic             ex_mem_read;
    logic [4:0]       ex_rt;
    logic             branch_taken;
    logic             dmem_req;
    logic             dmem_ready;

    logic             pc_write;
    logic             if_id_write;
    logic             if_id_flush;
    logic             id_ex_bubble;
    logic             pipe_hold;
    logic             mem_timeout;
    logic [31:0]      load_stall_cnt;
    logic [31:0]      flush_cnt;
    logic [31:0]      mem_wait_cnt;

    // Debug view of the controller FSM and its memory-wait counter.
    logic [0:0]       state;
    logic [CNT_W-1:0] wait_cnt;

    modport master (
        output id_rs, id_rt, id_uses_rt, ex_mem_read, ex_rt,
               branch_taken, dmem_req, dmem_ready,
        input  pc_write, if_id_write, if_id_flush, id_ex_bubble, pipe_hold,
               mem_timeout, load_stall_cnt, flush_cnt, mem_wait_cnt,
               state, wait_cnt
    );

    modport slave (
        input  id_rs, id_rt, id_uses_rt, ex_mem_read, ex_rt,
               branch_taken, dmem_req, dmem_ready,
        output pc_write, if_id_write, if_id_flush, id_ex_bubble, pipe_hold,
               mem_timeout, load_stall_cnt, flush_cnt, mem_wait_cnt,
               state, wait_cnt
    );
endinterface

// File: rtl/id_ex_hazard_ctrl.sv
// id_ex_hazard_ctrl
//
// Hazard controller for the 5-stage core. It sequences PC, IF/ID and ID/EX.
// It stalls one cycle on a load-use hazard, squashes the two wrong-path
// instructions on a taken branch, and freezes the whole pipeline while data
// memory is busy. A watchdog flag is set after TIMEOUT wait cycles.
//
// Ports:
//   clk    - rising-edge clock
//   reset  - asynchronous, active-low reset (0 = in reset)
//   hz     - id_ex_hazard_ctrl_if.slave bundle:
//            in : id_rs, id_rt, id_uses_rt, ex_mem_read, ex_rt,
//                 branch_taken, dmem_req, dmem_ready
//            out: pc_write, if_id_write, if_id_flush, id_ex_bubble,
//                 pipe_hold, mem_timeout, load_stall_cnt, flush_cnt,
//                 mem_wait_cnt, state (debug), wait_cnt (debug)
//
// Parameters: TIMEOUT (1..2^CNT_W-1) wait cycles before mem_timeout sets,
// and CNT_W, the width of the wait counter.
//
// Build option: define STALL_CNT_EN to build the three 32-bit saturating
// event counters. Without it those outputs are tied to zero.
module id_ex_hazard_ctrl #(
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    id_ex_hazard_ctrl_if.slave   hz
);

    localparam logic [0:0]       RUN      = 1'b0;
    localparam logic [0:0]       MEM_WAIT = 1'b1;
    localparam logic [CNT_W-1:0] TO_C     = CNT_W'(TIMEOUT);

    logic [0:0]       state;
    logic [CNT_W-1:0] wait_cnt;
    logic [CNT_W-1:0] wait_cnt_next;
    logic             mem_timeout;

    logic memwait;
    logic branch;
    logic loaduse;

    assign memwait = hz.dmem_req & ~hz.dmem_ready;
    assign branch  = hz.branch_taken;
    // Register $zero is never a real destination, so it cannot cause a hazard.
    assign loaduse = hz.ex_mem_read & (hz.ex_rt != 5'd0) &
                     ((hz.ex_rt == hz.id_rs) |
                      (hz.id_uses_rt & (hz.ex_rt == hz.id_rt)));

    // Control outputs. The reset term is combinational so that the pipeline
    // loads NOPs/bubbles while reset is low, even without a clock.
    always_comb begin
        hz.pc_write     = 1'b1;
        hz.if_id_write  = 1'b1;
        hz.if_id_flush  = 1'b0;
        hz.id_ex_bubble = 1'b0;
        hz.pipe_hold    = 1'b0;
        if (!reset) begin
            hz.pc_write     = 1'b0;
            hz.if_id_write  = 1'b0;
            hz.if_id_flush  = 1'b1;
            hz.id_ex_bubble = 1'b1;
        end else if (memwait) begin
            // Freeze everything. Any branch stays latched in EX and is
            // acted on in the first cycle without memwait.
            hz.pc_write     = 1'b0;
            hz.if_id_write  = 1'b0;
            hz.pipe_hold    = 1'b1;
        end else if (branch) begin
            hz.if_id_flush  = 1'b1;
            hz.id_ex_bubble = 1'b1;
        end else if (loaduse) begin
            hz.pc_write     = 1'b0;
            hz.if_id_write  = 1'b0;
            hz.id_ex_bubble = 1'b1;
        end
    end

    // The wait counter counts cycles spent frozen on memory and saturates at
    // TIMEOUT. The watchdog fires on the edge where it reaches TIMEOUT.
    always_comb begin
        wait_cnt_next = '0;
        if (memwait) begin
            if (wait_cnt >= TO_C)
                wait_cnt_next = TO_C;
            else
                wait_cnt_next = wait_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= RUN;
            wait_cnt    <= '0;
            mem_timeout <= 1'b0;
        end else begin
            state    <= memwait ? MEM_WAIT : RUN;
            wait_cnt <= wait_cnt_next;
            if (memwait && (wait_cnt_next == TO_C))
                mem_timeout <= 1'b1;
        end
    end

    assign hz.state       = state;
    assign hz.wait_cnt    = wait_cnt;
    assign hz.mem_timeout = mem_timeout;

`ifdef STALL_CNT_EN
    // Each counter counts cycles where its hazard wins priority.
    logic        win_mem;
    logic        win_br;
    logic        win_lu;
    logic [31:0] load_stall_q;
    logic [31:0] flush_q;
    logic [31:0] mem_wait_q;

    assign win_mem = memwait;
    assign win_br  = ~memwait & branch;
    assign win_lu  = ~memwait & ~branch & loaduse;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            load_stall_q <= '0;
            flush_q      <= '0;
            mem_wait_q   <= '0;
        end else begin
            if (win_lu && (load_stall_q != 32'hFFFF_FFFF))
                load_stall_q <= load_stall_q + 32'd1;
            if (win_br && (flush_q != 32'hFFFF_FFFF))
                flush_q <= flush_q + 32'd1;
            if (win_mem && (mem_wait_q != 32'hFFFF_FFFF))
                mem_wait_q <= mem_wait_q + 32'd1;
        end
    end

    assign hz.load_stall_cnt = load_stall_q;
    assign hz.flush_cnt      = flush_q;
    assign hz.mem_wait_cnt   = mem_wait_q;
`else
    assign hz.load_stall_cnt = 32'd0;
    assign hz.flush_cnt      = 32'd0;
    assign hz.mem_wait_cnt   = 32'd0;
`endif

endmodule

// File: tb/tb_id_ex_hazard_ctrl.sv
// tb_id_ex_hazard_ctrl
//
// Directed bench for id_ex_hazard_ctrl with TIMEOUT=4. Inputs change 1 ns
// after a rising edge. Combinational outputs are checked 2 ns later, and
// registered state is checked 1 ns after the following edge. Expected
// counter values are zero unless STALL_CNT_EN is defined.
module tb_id_ex_hazard_ctrl;

    localparam int TIMEOUT = 4;
    localparam int CNT_W   = 8;
`ifdef STALL_CNT_EN
    localparam bit CNT_ON = 1'b1;
`else
    localparam bit CNT_ON = 1'b0;
`endif

    logic clk;
    logic reset;

    int vectors;
    int miscompares;

    id_ex_hazard_ctrl_if #(.CNT_W(CNT_W)) hz_if ();

    id_ex_hazard_ctrl #(
        .TIMEOUT (TIMEOUT),
        .CNT_W   (CNT_W)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .hz    (hz_if)
    );

    // Clock: rising edges at 5, 15, 25, ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
            $error("miscompare on %s", tag);
        end
    endtask

    // Expected bit order: {pc_write, if_id_write, if_id_flush, id_ex_bubble, pipe_hold}.
    task automatic check_ctrl(input string tag, input logic [4:0] exp);
        check(tag, {27'd0, hz_if.pc_write, hz_if.if_id_write, hz_if.if_id_flush,
                    hz_if.id_ex_bubble, hz_if.pipe_hold}, {27'd0, exp});
    endtask

    task automatic check_cnts(input string tag, input int ls, input int fl, input int mw);
        check({tag, "_ls"}, hz_if.load_stall_cnt, CNT_ON ? 32'(ls) : 32'd0);
        check({tag, "_fl"}, hz_if.flush_cnt,      CNT_ON ? 32'(fl) : 32'd0);
        check({tag, "_mw"}, hz_if.mem_wait_cnt,   CNT_ON ? 32'(mw) : 32'd0);
    endtask

    task automatic check_regs(input string tag, input logic st, input int wc, input logic to);
        check({tag, "_state"}, {31'd0, hz_if.state}, {31'd0, st});
        check({tag, "_wait"},  {24'd0, hz_if.wait_cnt}, 32'(wc));
        check({tag, "_tmo"},   {31'd0, hz_if.mem_timeout}, {31'd0, to});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        hz_if.id_rs        = 5'd0;
        hz_if.id_rt        = 5'd0;
        hz_if.id_uses_rt   = 1'b0;
        hz_if.ex_mem_read  = 1'b0;
        hz_if.ex_rt        = 5'd0;
        hz_if.branch_taken = 1'b0;
        hz_if.dmem_req     = 1'b0;
        hz_if.dmem_ready   = 1'b0;
    endtask

    localparam logic [4:0] NORMAL  = 5'b11000;
    localparam logic [4:0] STALL   = 5'b00010;
    localparam logic [4:0] FLUSH   = 5'b11110;
    localparam logic [4:0] HOLD    = 5'b00001;
    localparam logic [4:0] IN_RST  = 5'b00110;

    initial begin
        vectors     = 0;
        miscompares = 0;

        // Reset with hazards present: the reset outputs must win.
        idle();
        reset              = 1'b0;
        hz_if.dmem_req     = 1'b1;
        hz_if.branch_taken = 1'b1;
        #2;
        check_ctrl("rst_ctrl", IN_RST);
        check_regs("rst", 1'b0, 0, 1'b0);
        check_cnts("rst", 0, 0, 0);
        tick();
        tick();
        check_regs("rst_clk", 1'b0, 0, 1'b0);

        idle();
        reset = 1'b1;
        #2;
        check_ctrl("post_rst_ctrl", NORMAL);
        tick();
        check_regs("post_rst", 1'b0, 0, 1'b0);

        // Load-use through rs: one bubble, then normal flow.
        hz_if.ex_mem_read = 1'b1;
        hz_if.ex_rt       = 5'd5;
        hz_if.id_rs       = 5'd5;
        #2;
        check_ctrl("lu_rs", STALL);
        tick();
        hz_if.ex_mem_read = 1'b0;
        #2;
        check_ctrl("lu_after", NORMAL);
        check_cnts("lu", 1, 0, 0);

        // $zero destination: no stall.
        hz_if.ex_mem_read = 1'b1;
        hz_if.ex_rt       = 5'd0;
        hz_if.id_rs       = 5'd0;
        #2;
        check_ctrl("lu_zero", NORMAL);
        tick();

        // rt matches but ID does not read rt: no stall.
        hz_if.ex_rt      = 5'd5;
        hz_if.id_rs      = 5'd3;
        hz_if.id_rt      = 5'd5;
        hz_if.id_uses_rt = 1'b0;
        #2;
        check_ctrl("lu_rt_unused", NORMAL);
        tick();

        // Same fields, rt read: stall.
        hz_if.id_uses_rt = 1'b1;
        #2;
        check_ctrl("lu_rt_used", STALL);
        tick();
        check_cnts("lu_rt", 2, 0, 0);

        // Taken branch overrides a concurrent load-use.
        hz_if.id_rs        = 5'd5;
        hz_if.branch_taken = 1'b1;
        #2;
        check_ctrl("br_lu", FLUSH);
        tick();
        idle();
        check_cnts("br", 2, 1, 0);

        // Three-cycle memory wait, then release.
        hz_if.dmem_req = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            #2;
            check_ctrl($sformatf("mw_hold%0d", i), HOLD);
            tick();
            check_regs($sformatf("mw_%0d", i), 1'b1, i, 1'b0);
        end
        hz_if.dmem_ready = 1'b1;
        #2;
        check_ctrl("mw_ready", NORMAL);
        tick();
        check_regs("mw_done", 1'b0, 0, 1'b0);
        check_cnts("mw", 2, 1, 3);

        // Ready in the request cycle: no hold, no wait state.
        hz_if.dmem_ready = 1'b1;
        #2;
        check_ctrl("mw_1cyc", NORMAL);
        tick();
        check_regs("mw_1cyc", 1'b0, 0, 1'b0);

        // Watchdog: fires on the 4th wait edge, the counter saturates, and the flag is sticky.
        hz_if.dmem_ready = 1'b0;
        tick();
        tick();
        tick();
        check_regs("to_3", 1'b1, 3, 1'b0);
        tick();
        check_regs("to_4", 1'b1, 4, 1'b1);
        tick();
        check_regs("to_sat", 1'b1, 4, 1'b1);
        hz_if.dmem_ready = 1'b1;
        tick();
        check_regs("to_ready", 1'b0, 0, 1'b1);
        idle();
        tick();
        check_regs("to_sticky", 1'b0, 0, 1'b1);
        check_cnts("to", 2, 1, 8);

        // Branch held through a 2-cycle wait: the flush happens only once ready.
        hz_if.dmem_req     = 1'b1;
        hz_if.branch_taken = 1'b1;
        #2;
        check_ctrl("bw_hold1", HOLD);
        tick();
        #1;
        check_ctrl("bw_hold2", HOLD);
        tick();
        hz_if.dmem_ready = 1'b1;
        #2;
        check_ctrl("bw_release", FLUSH);
        tick();
        idle();
        check_regs("bw_done", 1'b0, 0, 1'b1);
        check_cnts("bw", 2, 2, 10);

        // Dropping the request also leaves MEM_WAIT.
        hz_if.dmem_req = 1'b1;
        tick();
        check_regs("drop_in", 1'b1, 1, 1'b1);
        hz_if.dmem_req = 1'b0;
        tick();
        check_regs("drop_out", 1'b0, 0, 1'b1);

        // Reset in the middle of a wait aborts it at once, without a clock edge.
        hz_if.dmem_req = 1'b1;
        tick();
        check_regs("arst_pre", 1'b1, 1, 1'b1);
        #2;
        reset = 1'b0;
        #1;
        check_regs("arst", 1'b0, 0, 1'b0);
        check_ctrl("arst_ctrl", IN_RST);
        check_cnts("arst", 0, 0, 0);
        idle();
        #2;
        reset = 1'b1;
        tick();
        check_regs("arst_rel", 1'b0, 0, 1'b0);
        #1;
        check_ctrl("arst_rel_ctrl", NORMAL);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
